// File: rtl/square_renderer_if.sv
// -----------------------------------------------------------------------------
// square_renderer_if
//
// Bundles the signals exchanged between the square renderer and its
// surroundings: the VGA sync counters, the square-motion generator's packed
// position bus, the player box coordinates, and the renderer's colour and
// collision outputs.
//
// Signals:
//   refresh_tick  frame marker; its rising edge is the frame boundary
//   video_on      current pixel lies inside the visible area
//   pixel_x/y     current pixel column / row (10 bits each)
//   num_squares   number of active slots (values above 16 mean 16)
//   position      16 x 40-bit slots:
//                 speed_y[39:30] speed_x[29:20] pos_y[19:10] pos_x[9:0]
//   player_x/y    player box top-left corner
//   rgb           pixel colour, RGB444
//   square_on     pixel is covered by an active square
//   hit_mask      per-square overlap with the player over the last frame
//   hit_valid     one-cycle pulse when hit_mask updates
//
// Modports:
//   master  - the environment: drives the pixel/position side, reads colour
//   slave   - the renderer itself
// -----------------------------------------------------------------------------
interface square_renderer_if;

  logic         refresh_tick;
  logic         video_on;
  logic [9:0]   pixel_x;
  logic [9:0]   pixel_y;
  logic [5:0]   num_squares;
  logic [639:0] position;
  logic [9:0]   player_x;
  logic [9:0]   player_y;
  logic [11:0]  rgb;
  logic         square_on;
  logic [15:0]  hit_mask;
  logic         hit_valid;

  modport master (
    output refresh_tick,
    output video_on,
    output pixel_x,
    output pixel_y,
    output num_squares,
    output position,
    output player_x,
    output player_y,
    input  rgb,
    input  square_on,
    input  hit_mask,
    input  hit_valid
  );

  modport slave (
    input  refresh_tick,
    input  video_on,
    input  pixel_x,
    input  pixel_y,
    input  num_squares,
    input  position,
    input  player_x,
    input  player_y,
    output rgb,
    output square_on,
    output hit_mask,
    output hit_valid
  );

endinterface

// File: rtl/square_renderer.sv
// -----------------------------------------------------------------------------
// square_renderer
//
// Consumer end of the packed square-position bus. At every frame boundary
// (rising edge of refresh_tick) it snapshots the x/y of all 16 slots and the
// clamped active count, so the image drawn during a frame never tears even if
// the motion generator updates the bus mid-frame. Each pixel is then tested
// against every active square and the live player box; the colour result is
// produced through a 2-stage pipeline (inputs at cycle n -> outputs at n+2).
// Square/player overlaps seen during a frame are OR-accumulated and published
// on hit_mask at the next frame boundary, with a one-cycle hit_valid pulse.
//
// Ports:
//   clk    system clock
//   reset  synchronous, active-high reset
//   bus    square_renderer_if.slave (pixel, position, player, colour, hits)
//
// Parameters:
//   SQ_SIZE, PLAYER_SIZE            edge length in pixels
//   SQ_COLOR, PLAYER_COLOR, BG_COLOR RGB444 colours
//
// Build option:
//   SQUARE_PALETTE_EN  when defined, each square takes its colour from a fixed
//                      16-entry palette indexed by the lowest-numbered covering
//                      slot. When undefined every square uses SQ_COLOR and no
//                      index logic exists.
// -----------------------------------------------------------------------------
module square_renderer #(
  parameter int          SQ_SIZE      = 16,
  parameter int          PLAYER_SIZE  = 16,
  parameter logic [11:0] SQ_COLOR     = 12'hF00,
  parameter logic [11:0] PLAYER_COLOR = 12'h0F0,
  parameter logic [11:0] BG_COLOR     = 12'h000
) (
  input  logic              clk,
  input  logic              reset,
  square_renderer_if.slave  bus
);

  localparam int NUM_SLOTS = 16;
  localparam int SLOT_W    = 40;
  localparam int POS_W     = 10;

  // Spans are 11 bits wide so that a square placed near column/row 1023
  // extends past the screen edge instead of wrapping back to 0.
  localparam logic [10:0] SQ_SPAN     = 11'(SQ_SIZE);
  localparam logic [10:0] PLAYER_SPAN = 11'(PLAYER_SIZE);

`ifdef SQUARE_PALETTE_EN
  localparam logic [11:0] PALETTE [NUM_SLOTS] = '{
    12'hF00, 12'hF80, 12'hFF0, 12'h8F0,
    12'h0FF, 12'h08F, 12'h00F, 12'h80F,
    12'hF0F, 12'hF08, 12'hFFF, 12'h888,
    12'hA50, 12'h5A0, 12'h05A, 12'hA05
  };
`endif

  // ---------------------------------------------------------------------------
  // Frame boundary detection
  // ---------------------------------------------------------------------------
  logic tick_prev;
  logic frame_edge;

  // A level held high yields exactly one edge.
  assign frame_edge = bus.refresh_tick & ~tick_prev;

  // ---------------------------------------------------------------------------
  // Per-frame snapshot of the position bus
  // ---------------------------------------------------------------------------
  logic [POS_W-1:0] snap_x [NUM_SLOTS];
  logic [POS_W-1:0] snap_y [NUM_SLOTS];
  logic [4:0]       count_snap;
  logic [4:0]       count_clamped;

  always_comb begin
    count_clamped = (bus.num_squares > 6'd16) ? 5'd16 : bus.num_squares[4:0];
  end

  // NOTE: sequential state is written with non-blocking assignments so every
  // register samples the pre-edge value of its inputs, independent of the
  // order of statements or of always blocks.
  always_ff @(posedge clk) begin
    if (reset) begin
      tick_prev  <= 1'b0;
      count_snap <= 5'd0;
      // NOTE: the snapshot array is a small register file, not a RAM, so it is
      // cleared on reset; inactive slots are also masked by count_snap.
      for (int i = 0; i < NUM_SLOTS; i++) begin
        snap_x[i] <= '0;
        snap_y[i] <= '0;
      end
    end else begin
      tick_prev <= bus.refresh_tick;
      if (frame_edge) begin
        count_snap <= count_clamped;
        // Speed fields are not needed for drawing and are never captured.
        for (int i = 0; i < NUM_SLOTS; i++) begin
          snap_x[i] <= bus.position[SLOT_W*i +: POS_W];
          snap_y[i] <= bus.position[SLOT_W*i + POS_W +: POS_W];
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Coverage tests for the current pixel
  // ---------------------------------------------------------------------------
  logic [NUM_SLOTS-1:0] in_sq;
  logic                 in_player;
  logic [NUM_SLOTS-1:0] hit_now;

  // NOTE: every signal driven from always_comb gets a default at the top of
  // the block, so no path through it can leave a value held (no latch).
  always_comb begin
    in_sq = '0;
    for (int i = 0; i < NUM_SLOTS; i++) begin
      in_sq[i] = (5'(i) < count_snap) &&
                 (bus.pixel_x >= snap_x[i]) &&
                 ({1'b0, bus.pixel_x} < ({1'b0, snap_x[i]} + SQ_SPAN)) &&
                 (bus.pixel_y >= snap_y[i]) &&
                 ({1'b0, bus.pixel_y} < ({1'b0, snap_y[i]} + SQ_SPAN));
    end
  end

  // The player box is drawn from the live coordinates, not the snapshot.
  always_comb begin
    in_player = (bus.pixel_x >= bus.player_x) &&
                ({1'b0, bus.pixel_x} < ({1'b0, bus.player_x} + PLAYER_SPAN)) &&
                (bus.pixel_y >= bus.player_y) &&
                ({1'b0, bus.pixel_y} < ({1'b0, bus.player_y} + PLAYER_SPAN));
  end

  // Overlaps only count while the pixel is visible.
  assign hit_now = in_sq & {NUM_SLOTS{in_player & bus.video_on}};

`ifdef SQUARE_PALETTE_EN
  // Lowest-numbered covering slot wins: scan downwards so index 0 is last.
  logic [3:0] first_idx;

  always_comb begin
    first_idx = 4'd0;
    for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
      if (in_sq[i]) begin
        first_idx = 4'(i);
      end
    end
  end
`endif

  // ---------------------------------------------------------------------------
  // Stage 1: coverage flags, blanking, hit accumulation
  // ---------------------------------------------------------------------------
  logic [NUM_SLOTS-1:0] s1_in_sq;
  logic                 s1_in_player;
  logic                 s1_video_on;
  logic [NUM_SLOTS-1:0] hit_acc;
  logic [NUM_SLOTS-1:0] hit_mask_q;
  logic                 hit_valid_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      s1_in_sq     <= '0;
      s1_in_player <= 1'b0;
      s1_video_on  <= 1'b0;
      hit_acc      <= '0;
      hit_mask_q   <= '0;
      hit_valid_q  <= 1'b0;
    end else begin
      s1_in_sq     <= in_sq;
      s1_in_player <= in_player;
      s1_video_on  <= bus.video_on;
      hit_valid_q  <= frame_edge;
      if (frame_edge) begin
        // A hit landing on the boundary cycle belongs to the frame being
        // published, and also seeds the new frame's accumulator.
        hit_mask_q <= hit_acc | hit_now;
        hit_acc    <= hit_now;
      end else begin
        hit_acc    <= hit_acc | hit_now;
      end
    end
  end

`ifdef SQUARE_PALETTE_EN
  logic [3:0] s1_idx;

  always_ff @(posedge clk) begin
    if (reset) begin
      s1_idx <= 4'd0;
    end else begin
      s1_idx <= first_idx;
    end
  end
`endif

  // ---------------------------------------------------------------------------
  // Stage 2: colour selection and output registers
  // ---------------------------------------------------------------------------
  logic [11:0] sq_color;
  logic        s1_any_sq;
  logic [11:0] rgb_q;
  logic        square_on_q;

  assign s1_any_sq = |s1_in_sq;

`ifdef SQUARE_PALETTE_EN
  assign sq_color = PALETTE[s1_idx];
`else
  assign sq_color = SQ_COLOR;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      rgb_q       <= 12'h000;
      square_on_q <= 1'b0;
    end else if (!s1_video_on) begin
      rgb_q       <= 12'h000;
      square_on_q <= 1'b0;
    end else begin
      // square_on reports square coverage even where the player is on top.
      square_on_q <= s1_any_sq;
      if (s1_in_player) begin
        rgb_q <= PLAYER_COLOR;
      end else if (s1_any_sq) begin
        rgb_q <= sq_color;
      end else begin
        rgb_q <= BG_COLOR;
      end
    end
  end

  assign bus.rgb       = rgb_q;
  assign bus.square_on = square_on_q;
  assign bus.hit_mask  = hit_mask_q;
  assign bus.hit_valid = hit_valid_q;

endmodule

// File: tb/tb_square_renderer.sv
// -----------------------------------------------------------------------------
// tb_square_renderer
//
// Self-checking bench for square_renderer (default build). Pixel results are
// pushed to a scoreboard queue tagged with the cycle they must appear on and
// compared by a monitor on the falling edge; frame-boundary hit reporting and
// reset behaviour are checked by hand-written sequences.
// -----------------------------------------------------------------------------
module tb_square_renderer;

  localparam logic [11:0] SQ_C = 12'hF00;
  localparam logic [11:0] PL_C = 12'h0F0;
  localparam logic [11:0] BG_C = 12'h000;

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  square_renderer_if bus ();

  square_renderer dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Scoreboard
  // ---------------------------------------------------------------------------
  typedef struct {
    int          due;
    logic [11:0] rgb;
    logic        sq;
    int          id;
  } sb_t;

  sb_t sb [$];
  sb_t cur;

  always @(negedge clk) begin
    while (sb.size() > 0 && sb[0].due <= cyc) begin
      cur = sb.pop_front();
      check($sformatf("px%0d_rgb", cur.id), 32'(bus.rgb), 32'(cur.rgb));
      check($sformatf("px%0d_square_on", cur.id), 32'(bus.square_on), 32'(cur.sq));
    end
  end

  // Drive one pixel right after a clock edge; its result is due two edges later.
  task automatic apply_px(input int x, input int y, input logic von,
                          input logic [11:0] exp_rgb, input logic exp_sq, input int id);
    @(posedge clk);
    #1;
    bus.pixel_x  = 10'(x);
    bus.pixel_y  = 10'(y);
    bus.video_on = von;
    sb.push_back('{due: cyc + 2, rgb: exp_rgb, sq: exp_sq, id: id});
  endtask

  task automatic drain();
    for (int k = 0; k < 8 && sb.size() > 0; k++) @(posedge clk);
    check("scoreboard_drain", 32'(sb.size()), 32'd0);
  endtask

  // Slot position; speed fields get random junk since they must be ignored.
  task automatic set_slot(input int i, input int x, input int y);
    bus.position[40*i +: 10]      = 10'(x);
    bus.position[40*i + 10 +: 10] = 10'(y);
    bus.position[40*i + 20 +: 20] = 20'($urandom);
  endtask

  // Raise refresh_tick for 'hold' cycles with the screen blanked and check the
  // single hit_valid pulse and the published mask.
  task automatic frame_tick(input logic [15:0] exp_mask, input int hold, input string name);
    @(posedge clk);
    #1;
    bus.video_on     = 1'b0;
    bus.refresh_tick = 1'b1;
    @(posedge clk);
    #1;
    check({name, "_hit_valid"}, 32'(bus.hit_valid), 32'd1);
    check({name, "_hit_mask"}, 32'(bus.hit_mask), 32'(exp_mask));
    for (int k = 1; k < hold; k++) begin
      @(posedge clk);
      #1;
      check({name, "_hit_valid_held"}, 32'(bus.hit_valid), 32'd0);
    end
    bus.refresh_tick = 1'b0;
    @(posedge clk);
    #1;
    check({name, "_hit_valid_end"}, 32'(bus.hit_valid), 32'd0);
  endtask

  // ---------------------------------------------------------------------------
  // Table of single-square vectors (slot0 at (100,50), player at (1000,1000))
  // ---------------------------------------------------------------------------
  typedef struct {
    int          x;
    int          y;
    logic        von;
    logic [11:0] rgb;
    logic        sq;
  } vec_t;

  vec_t vecs [10];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vecs[0] = '{100,  50,   1'b1, SQ_C, 1'b1};  // top-left corner
    vecs[1] = '{115,  65,   1'b1, SQ_C, 1'b1};  // bottom-right corner
    vecs[2] = '{116,  50,   1'b1, BG_C, 1'b0};  // one past right edge
    vecs[3] = '{100,  66,   1'b1, BG_C, 1'b0};  // one past bottom edge
    vecs[4] = '{99,   50,   1'b1, BG_C, 1'b0};  // one before left edge
    vecs[5] = '{100,  49,   1'b1, BG_C, 1'b0};  // one before top edge
    vecs[6] = '{100,  50,   1'b0, 12'h000, 1'b0};  // blanked
    vecs[7] = '{1005, 1005, 1'b1, PL_C, 1'b0};  // player only
    vecs[8] = '{1015, 1015, 1'b1, PL_C, 1'b0};  // player far corner
    vecs[9] = '{1016, 1005, 1'b1, BG_C, 1'b0};  // just right of player

    reset            = 1'b1;
    bus.refresh_tick = 1'b0;
    bus.video_on     = 1'b0;
    bus.pixel_x      = '0;
    bus.pixel_y      = '0;
    bus.num_squares  = '0;
    bus.position     = '0;
    bus.player_x     = 10'd1000;
    bus.player_y     = 10'd1000;
    repeat (3) @(posedge clk);
    #1;
    check("reset_rgb", 32'(bus.rgb), 32'd0);
    check("reset_square_on", 32'(bus.square_on), 32'd0);
    check("reset_hit_mask", 32'(bus.hit_mask), 32'd0);
    check("reset_hit_valid", 32'(bus.hit_valid), 32'd0);
    reset = 1'b0;

    // Basic snapshot and pixel table
    set_slot(0, 100, 50);
    bus.num_squares = 6'd1;
    frame_tick(16'h0000, 1, "frame_first");
    for (int i = 0; i < 10; i++) begin
      apply_px(vecs[i].x, vecs[i].y, vecs[i].von, vecs[i].rgb, vecs[i].sq, i);
    end
    drain();

    // Tear-free: bus moves mid-frame, drawing follows only after the edge.
    // The edge is held high for 3 cycles to confirm a single pulse.
    set_slot(0, 300, 50);
    apply_px(100, 50, 1'b1, SQ_C, 1'b1, 100);
    apply_px(300, 50, 1'b1, BG_C, 1'b0, 101);
    drain();
    frame_tick(16'h0000, 3, "frame_tear");
    apply_px(100, 50, 1'b1, BG_C, 1'b0, 102);
    apply_px(300, 50, 1'b1, SQ_C, 1'b1, 103);
    drain();

    // Collision: player (100,50), square (108,58)
    set_slot(0, 108, 58);
    frame_tick(16'h0000, 1, "frame_coll_setup");
    bus.player_x = 10'd100;
    bus.player_y = 10'd50;
    apply_px(110, 60, 1'b1, PL_C, 1'b1, 200);  // overlap: player wins colour
    apply_px(104, 54, 1'b1, PL_C, 1'b0, 201);  // player only
    apply_px(120, 70, 1'b1, SQ_C, 1'b1, 202);  // square only
    drain();
    frame_tick(16'h0001, 1, "frame_coll_hit");
    bus.player_x = 10'd1000;
    bus.player_y = 10'd1000;
    apply_px(110, 60, 1'b1, SQ_C, 1'b1, 203);
    drain();
    frame_tick(16'h0000, 1, "frame_coll_clear");

    // Count clamp and masking
    bus.num_squares = 6'd0;
    frame_tick(16'h0000, 1, "frame_count0");
    apply_px(110, 60, 1'b1, BG_C, 1'b0, 300);
    drain();
    for (int i = 0; i < 16; i++) set_slot(i, i * 50, 200);
    bus.num_squares = 6'd40;
    frame_tick(16'h0000, 1, "frame_count40");
    apply_px(755, 205, 1'b1, SQ_C, 1'b1, 301);  // slot 15
    apply_px(5,   205, 1'b1, SQ_C, 1'b1, 302);  // slot 0
    apply_px(760, 216, 1'b1, BG_C, 1'b0, 303);
    drain();
    bus.num_squares = 6'd15;
    frame_tick(16'h0000, 1, "frame_count15");
    apply_px(755, 205, 1'b1, BG_C, 1'b0, 304);  // slot 15 now inactive
    apply_px(705, 205, 1'b1, SQ_C, 1'b1, 305);  // slot 14 still drawn
    drain();

    // Right-edge wrap
    set_slot(0, 1015, 300);
    bus.num_squares = 6'd1;
    frame_tick(16'h0000, 1, "frame_wrap");
    apply_px(1020, 305, 1'b1, SQ_C, 1'b1, 400);
    apply_px(5,    305, 1'b1, BG_C, 1'b0, 401);
    apply_px(1023, 315, 1'b1, SQ_C, 1'b1, 402);
    drain();

    // Hit at the screen edge, then reset in the middle of the next frame
    bus.player_x = 10'd1010;
    bus.player_y = 10'd300;
    apply_px(1020, 305, 1'b1, PL_C, 1'b1, 500);
    drain();
    frame_tick(16'h0001, 1, "frame_edge_hit");
    @(posedge clk);
    #1;
    bus.pixel_x  = 10'd1020;
    bus.pixel_y  = 10'd305;
    bus.video_on = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("pre_reset_rgb", 32'(bus.rgb), 32'(PL_C));
    check("pre_reset_hit_mask", 32'(bus.hit_mask), 32'h1);
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    check("mid_reset_rgb", 32'(bus.rgb), 32'd0);
    check("mid_reset_square_on", 32'(bus.square_on), 32'd0);
    check("mid_reset_hit_mask", 32'(bus.hit_mask), 32'd0);
    check("mid_reset_hit_valid", 32'(bus.hit_valid), 32'd0);
    // Snapshot is empty after reset: only the live player box remains.
    apply_px(1020, 305, 1'b1, PL_C, 1'b0, 600);
    drain();
    frame_tick(16'h0000, 1, "frame_post_reset");
    apply_px(1020, 305, 1'b1, PL_C, 1'b1, 601);
    drain();
    frame_tick(16'h0001, 1, "frame_post_reset_hit");

    // Blanking over a square and the player
    apply_px(1020, 305, 1'b0, 12'h000, 1'b0, 700);
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/square_renderer.md
Name: square_renderer

Overview:
- Consumer end of the packed square-position bus produced by the square-motion generator.
- Once per frame it snapshots the 16-slot position bus, then tests each VGA pixel against every active square and drives the colour output through a 2-stage pipeline.
- Also accumulates per-frame square/player overlap flags for game logic.
- Sits between the motion generator / VGA sync counters and the RGB output mux.

Parameters:
- SQ_SIZE, 16, square edge length in pixels.
- PLAYER_SIZE, 16, player box edge length in pixels.
- SQ_COLOR, 12'hF00, square colour (RGB444).
- PLAYER_COLOR, 12'h0F0, player box colour.
- BG_COLOR, 12'h000, background colour.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- refresh_tick  in  1  frame marker; its rising edge is the frame boundary
- video_on  in  1  pixel is inside the visible area
- pixel_x  in  10  current pixel column
- pixel_y  in  10  current pixel row
- num_squares  in  6  number of active slots; values above 16 are treated as 16
- position  in  640  slot i at bits [40i+39:40i]: speed_y[39:30], speed_x[29:20], pos_y[19:10], pos_x[9:0]
- player_x  in  10  player box left edge
- player_y  in  10  player box top edge
- rgb  out  12  pixel colour
- square_on  out  1  pixel is covered by an active square
- hit_mask  out  16  bit i set if square i overlapped the player during the last completed frame
- hit_valid  out  1  one-cycle pulse when hit_mask updates

Behaviour:
- Clock and reset: one clock (clk). reset is synchronous and active-high.
- Reset values: rgb=0, square_on=0, hit_mask=0, hit_valid=0. Snapshot registers, active count, hit accumulator and pipeline registers all clear. refresh_tick edge-detect register clears to 0.
- Edge detect: previous value of refresh_tick is registered; edge = refresh_tick & ~prev. A level held high causes exactly one edge.
- On edge: latch pos_x/pos_y of all 16 slots plus min(num_squares,16) into snapshot registers. Speed fields are ignored. The bus is not sampled at any other time, so the drawn image is tear-free.
- Coverage test for slot i: active if i < count_snap. in_sq = active & px>=x & px<x+SQ_SIZE & py>=y & py<y+SQ_SIZE. Use 11-bit sums so squares near 1023 do not wrap.
- Player coverage: same test using player_x/player_y and PLAYER_SIZE (live inputs, not snapshotted).
- Pipeline: inputs at cycle n appear on rgb/square_on at n+2.
  - Stage 1 registers the 16 in_sq flags, in_player and video_on.
  - Stage 2 registers the outputs.
- Colour priority: video_on=0 gives rgb=0 and square_on=0. Otherwise PLAYER_COLOR if in_player, else square colour if any in_sq, else BG_COLOR. square_on = |in_sq & video_on, independent of player priority.
- Hit accumulator: OR-accumulates, in stage 1, (in_sq & {16{in_player}}) whenever video_on=1.
- On edge:
  - hit_mask <= accumulator, including any hit from the same cycle.
  - hit_valid = 1 for exactly one cycle.
  - Accumulator restarts from that cycle's stage-1 hit only.
- num_squares=0: no square is ever drawn; hit_mask reads 0 after the next frame.
- Reset asserted mid-frame: everything clears. The first post-reset edge still pulses hit_valid, with hit_mask reflecting only post-reset hits.

Optional Feature:
- Macro: SQUARE_PALETTE_EN.
- Defined: each square's colour comes from a fixed 16-entry palette indexed by the lowest-numbered covering slot. The priority encoder sits in stage 1, and the registered index feeds stage 2. Latency is unchanged.
- Undefined: all squares use SQ_SIZE-independent SQ_COLOR and no index logic is built.

Test Plan:
- Snapshot: slot0 pos_x=100 pos_y=50, num_squares=1, one refresh_tick edge, then scan pixel (100,50) with video_on=1 -> two cycles later square_on=1, rgb=12'hF00. Pixel (116,50) -> square_on=0, rgb=BG_COLOR.
- Tear-free: change position mid-frame to pos_x=300 with no edge -> pixel (100,50) still drawn, (300,50) not drawn. After the next edge the roles swap.
- Count clamp/mask: num_squares=0 -> no square pixels. num_squares=40 with all 16 slots valid -> slot 15 drawn.
- Wrap: pos_x=1015, pixel_x=1020 -> covered. pixel_x=5 -> not covered.
- Collision: player at (100,50), square0 at (108,58), scan the overlap, then an edge -> hit_valid pulses 1 cycle, hit_mask=16'h0001. Next frame with no overlap -> hit_mask=0.
- Reset mid-frame and blanking: assert reset 1 cycle -> rgb=0, hit_mask=0 on the next cycle. video_on=0 over a square -> rgb=0, square_on=0.
